alu_seq_responder: RTL and testbench

- Handshaked, sequential ALU responder; the execution end of the operand/opcode interface (a, b, sel -> 16-bit result) driven by upstream stimulus or control logic.
- Accepts one command per valid/ready handshake and executes it: single-cycle for logic/add/sub/shift, WIDTH-cycle shift-add for multiply.
- Returns the 2*WIDTH-bit result on a valid/ready output channel and holds it until consumed.

---
 rtl/alu_seq_pkg.sv | 19 +
 rtl/alu_shift_add_mul.sv | 73 +++++++
 rtl/alu_seq_responder.sv | 105 ++++++++++
 tb/tb_alu_seq_responder.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcode values and controller state encoding for the sequential ALU responder.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_NOT = 3'b110;
  localparam logic [2:0] OP_SHL = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one partial product per cycle, WIDTH iterations.
module alu_shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] addend;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               active_q, active_d;

  genvar gi;
  generate
    for (gi = 0; gi < 2*WIDTH; gi++) begin : g_addend
      assign addend[gi] = mcand_q[gi] & mplier_q[0];
    end
  endgenerate

  // product is the accumulator including this cycle's partial product,
  // so the final value is usable on the same edge that done is seen.
  assign product = acc_q + addend;
  assign done    = active_q && (cnt_q == LAST);

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    if (start) begin
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
      cnt_d    = '0;
      active_d = 1'b1;
    end else if (active_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = done ? '0 : cnt_q + 1'b1;
      active_d = !done;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/alu_seq_responder.sv
// Handshaked ALU: single-cycle logic/arith ops inline, multiply via the shift-add sub-block.
module alu_seq_responder
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] y,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] y_q, y_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] a_ext, b_ext, alu_res;
  logic [2*WIDTH-1:0] mul_product;
  logic               mul_start, mul_done;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == MUL);
  assign out_valid = out_valid_q;
  assign y         = y_q;

  alu_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    a_ext = {{WIDTH{1'b0}}, a};
    b_ext = {{WIDTH{1'b0}}, b};
    case (sel)
      OP_ADD:  alu_res = a_ext + b_ext;
      OP_SUB:  alu_res = a_ext - b_ext;
      OP_AND:  alu_res = a_ext & b_ext;
      OP_OR:   alu_res = a_ext | b_ext;
      OP_XOR:  alu_res = a_ext ^ b_ext;
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a};
      OP_SHL:  alu_res = a_ext << b[2:0];
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    out_valid_d = out_valid_q;
    mul_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (sel == OP_MUL) begin
            mul_start = 1'b1;
            state_d   = MUL;
          end else begin
            y_d         = alu_res;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      MUL: begin
        if (mul_done) begin
          y_d         = mul_product;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // y is deliberately left alone so it keeps its value after the handshake
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      y_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_alu_seq_responder.sv
// Bench for alu_seq_responder: directed vectors, backpressure, reset mid-multiply, random stream.
module tb_alu_seq_responder;
  import alu_seq_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [2:0]  sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] y;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  alu_seq_responder #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Reference: plain integer arithmetic truncated to the 16-bit result.
  function automatic logic [15:0] ref_alu(input logic [7:0] p, input logic [7:0] q,
                                          input logic [2:0] op);
    int unsigned ux = p;
    int unsigned uy = q;
    int unsigned r;
    case (op)
      3'd0:    r = ux + uy;
      3'd1:    r = ux - uy;
      3'd2:    r = ux * uy;
      3'd3:    r = ux & uy;
      3'd4:    r = ux | uy;
      3'd5:    r = ux ^ uy;
      3'd6:    r = 255 - ux;
      default: r = ux * (1 << (uy % 8));
    endcase
    return r[15:0];
  endfunction

  task automatic run_cmd(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                         input logic [2:0] ts, input logic [15:0] exp_y);
    int lat;
    check({tag, "_in_ready"}, in_ready, 1);
    a = ta; b = tb; sel = ts; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check({tag, "_busy"}, busy, (ts == OP_MUL));
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_lat"}, lat, (ts == OP_MUL) ? 9 : 1);
    check({tag, "_y"}, y, exp_y);
    $display("cmd %s sel=%0d a=%02h b=%02h y=%04h lat=%0d", tag, ts, ta, tb, y, lat);
    @(posedge clk); #1;
    check({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
  endtask

  // in_valid held high across commands; results collected in order against a model queue.
  task automatic stream(input string tag, input int n, input bit rand_ready);
    logic [15:0] expq[$];
    logic [15:0] yv;
    int sent = 0;
    int got  = 0;
    int cyc  = 0;
    bit acc, hs;
    a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
    in_valid = 1;
    while (got < n && cyc < 4000) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      #0;
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      yv  = y;
      if (acc) expq.push_back(ref_alu(a, b, sel));
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        if (sent < n) begin
          a = 8'($urandom); b = 8'($urandom); sel = 3'($urandom);
        end else begin
          in_valid = 0;
        end
      end
      if (hs) begin
        if (expq.size() == 0) begin
          check({tag, "_spurious"}, 1, 0);
        end else begin
          logic [15:0] e;
          e = expq.pop_front();
          check({tag, "_y"}, yv, e);
          $display("stream %s result %0d y=%04h expected=%04h", tag, got, yv, e);
        end
        got++;
      end
    end
    check({tag, "_count"}, got, n);
    check({tag, "_sent"}, sent, n);
    in_valid = 0; out_ready = 1;
    @(posedge clk); #1;
  endtask

  logic [15:0] dir_exp [8];

  initial begin
    dir_exp = '{16'h0147, 16'hFFC3, 16'h64CA, 16'h0080, 16'h00C7, 16'h0047, 16'h007A, 16'h0214};
    clk = 0; rst = 1; in_valid = 0; a = 0; b = 0; sel = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_state", {in_ready, out_valid, busy}, 3'b100);
    check("rst_y", y, 16'h0000);
    rst = 0;
    @(posedge clk); #1;

    for (int s = 0; s < 8; s++)
      run_cmd($sformatf("dir%0d", s), 8'h85, 8'hC2, 3'(s), dir_exp[s]);

    // Backpressure with a stray in_valid pulse that must be ignored.
    out_ready = 0;
    a = 8'hFF; b = 8'h01; sel = OP_ADD; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("bp_valid0", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_y", y, 16'h0100);
      check("bp_hold", {out_valid, in_ready}, 2'b10);
      if (i == 2) begin
        in_valid = 1; a = 8'h03; b = 8'h04; sel = OP_OR;
      end else begin
        in_valid = 0;
      end
      @(posedge clk); #1;
    end
    in_valid = 0;
    out_ready = 1;
    check("bp_rel_valid", out_valid, 1);
    @(posedge clk); #1;
    check("bp_after", {out_valid, in_ready}, 2'b01);
    check("bp_y_kept", y, 16'h0100);
    repeat (2) @(posedge clk);
    #1;
    check("bp_no_stray", out_valid, 0);
    $display("backpressure sequence y=%04h", y);

    run_cmd("mul_ffff", 8'hFF, 8'hFF, OP_MUL, 16'hFE01);
    run_cmd("mul_00c2", 8'h00, 8'hC2, OP_MUL, 16'h0000);
    run_cmd("mul_0180", 8'h01, 8'h80, OP_MUL, 16'h0080);

    // Reset in the 4th MUL cycle drops the operation.
    a = 8'h85; b = 8'hC2; sel = OP_MUL; in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rstmul_busy", busy, 1);
    rst = 1;
    @(posedge clk); #1;
    check("rstmul_state", {in_ready, out_valid, busy}, 3'b100);
    check("rstmul_y", y, 16'h0000);
    rst = 0;
    repeat (12) @(posedge clk);
    #1;
    check("rstmul_no_result", out_valid, 0);
    $display("reset mid-multiply y=%04h", y);
    run_cmd("post_rst_add", 8'h02, 8'h03, OP_ADD, 16'h0005);

    stream("b2b", 2, 1'b0);
    stream("rnd", 40, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
